// File: rtl/sdwr_scramble_tx.sv
// Serial transmit engine: bus-written bytes are double-buffered, LFSR-scrambled
// and sent LSB-first as start/8 data/stop frames at a programmable bit rate.
module sdwr_scramble_tx #(
   parameter int          DIV_W    = 8,
   parameter logic [5:0]  SEED_RST = 6'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sser_n,
   input  logic       ba13,
   input  logic       ba12,
   input  logic [3:0] ba_lo,
   input  logic       br_w,
   input  logic [7:0] bd_in,
   output logic [7:0] bd_out,
   output logic       bd_oe,
   output logic       sdwr,
   output logic       sdfrm,
   output logic       sdbit
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t           r_state;
   logic [7:0]       r_hold;
   logic [7:0]       r_sh;
   logic             r_hold_full;
   logic             r_ovr;
   logic [5:0]       r_lfsr;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;
   logic [2:0]       r_bit;
   logic             r_wr_prev;
   logic             r_rd_prev;
   logic             r_sdwr;
   logic             r_sdfrm;
   logic             r_sdbit;

   logic             w_sel;
   logic             w_wr_stb;
   logic             w_rd_stb;
   logic             w_data_wr;
   logic             w_busy;
   logic             w_bound;
   logic             w_unload;
   logic [5:0]       w_lfsr_nxt;
   logic [7:0]       w_sh_nxt;

   assign w_sel      = ~sser_n & ~ba13 & ba12;
   assign w_wr_stb   = w_sel & ~br_w & ~r_wr_prev;
   assign w_rd_stb   = w_sel & br_w & ~r_rd_prev;
   assign w_data_wr  = w_wr_stb & (ba_lo == 4'd0);
   assign w_busy     = (r_state != S_IDLE);
   assign w_bound    = (r_cnt == '0);
   // The holding register empties either from IDLE or at the end of a stop bit.
   assign w_unload   = r_hold_full & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bound));
   assign w_lfsr_nxt = {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
   assign w_sh_nxt   = {1'b0, r_sh[7:1]};

   assign sdwr  = r_sdwr;
   assign sdfrm = r_sdfrm;
   assign sdbit = r_sdbit;
   assign bd_oe = w_sel & br_w;

   // NOTE: every variable assigned here gets a default first so no latch is inferred.
   always_comb begin
      bd_out = 8'h00;
      if (bd_oe) begin
         case (ba_lo)
            4'd1:    bd_out = {5'b0, r_ovr, r_hold_full, w_busy};
            4'd3:    bd_out = 8'(r_div);
            default: bd_out = 8'h00;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_hold      <= 8'h00;
         r_sh        <= 8'h00;
         r_hold_full <= 1'b0;
         r_ovr       <= 1'b0;
         r_lfsr      <= SEED_RST;
         r_div       <= '0;
         r_cnt       <= '0;
         r_bit       <= 3'd0;
         r_wr_prev   <= 1'b0;
         r_rd_prev   <= 1'b0;
         r_sdwr      <= 1'b1;
         r_sdfrm     <= 1'b0;
         r_sdbit     <= 1'b0;
      end else begin
         r_wr_prev <= w_sel & ~br_w;
         r_rd_prev <= w_sel & br_w;

         if (w_wr_stb && ba_lo == 4'd2 && !w_busy)
            r_lfsr <= (bd_in[5:0] == 6'd0) ? 6'h01 : bd_in[5:0];
         if (w_wr_stb && ba_lo == 4'd3)
            r_div <= DIV_W'(bd_in);
         if (w_data_wr && r_hold_full && !w_unload)
            r_ovr <= 1'b1;
         else if (w_rd_stb && ba_lo == 4'd1)
            r_ovr <= 1'b0;

         if (w_data_wr && (!r_hold_full || w_unload)) begin
            r_hold      <= bd_in;
            r_hold_full <= 1'b1;
         end else if (w_unload) begin
            r_hold_full <= 1'b0;
         end

         r_sdbit <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_sdwr  <= 1'b1;
               r_sdfrm <= 1'b0;
               if (r_hold_full) begin
                  r_sh    <= r_hold;
                  r_state <= S_START;
                  r_cnt   <= r_div;
                  r_sdwr  <= 1'b0;
                  r_sdfrm <= 1'b1;
                  r_sdbit <= 1'b1;
               end
            end
            S_START: begin
               if (!w_bound) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_cnt   <= r_div;
                  r_sdbit <= 1'b1;
                  r_bit   <= 3'd0;
                  r_state <= S_DATA;
                  r_sdwr  <= r_sh[0] ^ r_lfsr[5];
               end
            end
            S_DATA: begin
               if (!w_bound) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_cnt   <= r_div;
                  r_sdbit <= 1'b1;
                  r_sh    <= w_sh_nxt;
                  r_lfsr  <= w_lfsr_nxt;
                  if (r_bit == 3'd7) begin
                     r_state <= S_STOP;
                     r_sdwr  <= 1'b1;
                  end else begin
                     r_bit  <= r_bit + 3'd1;
                     r_sdwr <= w_sh_nxt[0] ^ w_lfsr_nxt[5];
                  end
               end
            end
            default: begin
               if (!w_bound) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (r_hold_full) begin
                  r_cnt   <= r_div;
                  r_sdbit <= 1'b1;
                  r_sh    <= r_hold;
                  r_state <= S_START;
                  r_sdwr  <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
                  r_sdwr  <= 1'b1;
                  r_sdfrm <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdwr_scramble_tx.sv
// Bench for sdwr_scramble_tx: frame-level reference model compared every cycle,
// plus directed scenarios pinned with hand-computed values.
module tb_sdwr_scramble_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sser_n = 1'b1;
   logic       ba13 = 1'b0;
   logic       ba12 = 1'b0;
   logic [3:0] ba_lo = 4'd0;
   logic       br_w = 1'b1;
   logic [7:0] bd_in = 8'h00;
   logic [7:0] bd_out;
   logic       bd_oe;
   logic       sdwr;
   logic       sdfrm;
   logic       sdbit;

   sdwr_scramble_tx #(.DIV_W(8), .SEED_RST(6'h01)) dut (
      .clk(clk), .rst(rst), .sser_n(sser_n), .ba13(ba13), .ba12(ba12),
      .ba_lo(ba_lo), .br_w(br_w), .bd_in(bd_in), .bd_out(bd_out),
      .bd_oe(bd_oe), .sdwr(sdwr), .sdfrm(sdfrm), .sdbit(sdbit)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model (frame as a list of line levels) ----------------
   logic       chk_en = 1'b0;
   logic       m_hold, m_ovr, m_busy, m_wr_prev, m_rd_prev;
   logic [7:0] m_hold_byte, m_div;
   logic [5:0] m_lfsr;
   int         m_left;
   logic       m_bits[$];
   logic       m_sdwr, m_sdfrm, m_sdbit;
   logic       s_sel, s_wr_term, s_rd_term, s_wr_stb, s_rd_stb, s_busy_pre;

   task automatic build_frame(input logic [7:0] b);
      m_bits.delete();
      m_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         m_bits.push_back(b[i] ^ m_lfsr[5]);
         m_lfsr = {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
      end
      m_bits.push_back(1'b1);
   endtask

   always @(posedge clk) begin
      s_sel     = !sser_n && !ba13 && ba12;
      s_wr_term = s_sel && !br_w;
      s_rd_term = s_sel && br_w;
      if (rst) begin
         chk_en = 1'b1;
         m_hold = 0; m_ovr = 0; m_busy = 0; m_wr_prev = 0; m_rd_prev = 0;
         m_hold_byte = 0; m_div = 0; m_lfsr = 6'h01; m_left = 0;
         m_bits.delete();
         m_sdwr = 1; m_sdfrm = 0; m_sdbit = 0;
      end else begin
         s_wr_stb   = s_wr_term && !m_wr_prev;
         s_rd_stb   = s_rd_term && !m_rd_prev;
         m_wr_prev  = s_wr_term;
         m_rd_prev  = s_rd_term;
         s_busy_pre = m_busy;
         if (s_wr_stb && ba_lo == 2 && !s_busy_pre)
            m_lfsr = (bd_in[5:0] == 0) ? 6'h01 : bd_in[5:0];
         if (m_busy && m_left > 0) begin
            m_left--;
            m_sdbit = 0;
         end else if (m_bits.size() > 0) begin
            m_sdwr = m_bits.pop_front(); m_left = m_div; m_sdbit = 1;
         end else if (m_hold) begin
            build_frame(m_hold_byte);
            m_hold = 0; m_busy = 1; m_sdfrm = 1;
            m_sdwr = m_bits.pop_front(); m_left = m_div; m_sdbit = 1;
         end else begin
            m_busy = 0; m_sdfrm = 0; m_sdwr = 1; m_sdbit = 0;
         end
         if (s_wr_stb && ba_lo == 0) begin
            if (!m_hold) begin m_hold = 1; m_hold_byte = bd_in; end
            else m_ovr = 1;
         end
         if (s_wr_stb && ba_lo == 3) m_div = bd_in;
         if (s_rd_stb && ba_lo == 1) m_ovr = 0;
      end
   end

   logic       c_oe;
   logic [7:0] c_out;
   always @(negedge clk) begin
      if (chk_en) begin
         c_oe  = !sser_n && !ba13 && ba12 && br_w;
         c_out = 8'h00;
         if (c_oe && ba_lo == 1) c_out = {5'b0, m_ovr, m_hold, m_busy};
         if (c_oe && ba_lo == 3) c_out = m_div;
         check("sdwr",   sdwr,   m_sdwr);
         check("sdfrm",  sdfrm,  m_sdfrm);
         check("sdbit",  sdbit,  m_sdbit);
         check("bd_oe",  bd_oe,  c_oe);
         check("bd_out", bd_out, c_out);
      end
   end

   // Frame-envelope monitor: counts frame starts and length of the last sdfrm burst.
   int   ncyc = 0, frm_start = 0, last_len = 0, n_frm_starts = 0;
   logic prev_frm = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         if (sdfrm && !prev_frm) begin frm_start = ncyc; n_frm_starts++; end
         if (!sdfrm && prev_frm) last_len = ncyc - frm_start;
         prev_frm = sdfrm;
      end
      ncyc++;
   end

   // ---------------- bus tasks ----------------
   task automatic deselect();
      sser_n = 1'b1; br_w = 1'b1; ba13 = 1'b0; ba12 = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic bus_write(input logic [3:0] idx, input logic [7:0] v);
      sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; ba_lo = idx; br_w = 1'b0; bd_in = v;
      tick();
      deselect();
      tick();
   endtask

   task automatic bus_read(input logic [3:0] idx, output logic [7:0] v);
      sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; ba_lo = idx; br_w = 1'b1;
      @(negedge clk);
      v = bd_out;
      tick();
      deselect();
      tick();
   endtask

   task automatic capture_frame(output logic [9:0] s);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         s[i] = sdwr;
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (sdfrm && k < 500) begin @(negedge clk); k++; end
      check("idle_timeout", sdfrm, 1'b0);
      @(negedge clk);
      #1;
   endtask

   logic [7:0] rd;
   logic [9:0] seq;
   int         f0;

   initial begin
      deselect();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;

      // reset state
      bus_read(4'd1, rd);
      check("rst_status", rd, 8'h00);
      check("rst_sdwr", sdwr, 1'b1);
      check("rst_sdfrm", sdfrm, 1'b0);

      // DIV=0, SEED=1, DATA=0
      bus_write(4'd2, 8'h01);
      bus_write(4'd0, 8'h00);
      capture_frame(seq);
      check("seq_seed1", seq, 10'h240);
      wait_idle();
      bus_read(4'd1, rd);
      check("busy_drop", rd, 8'h00);

      // back-to-back frames with overrun
      bus_write(4'd3, 8'd3);
      bus_write(4'd0, 8'hA5);
      bus_write(4'd0, 8'h3C);
      bus_write(4'd0, 8'hFF);
      bus_read(4'd1, rd);
      check("status_ovr", rd, 8'h07);
      bus_read(4'd1, rd);
      check("status_ovr_clr", rd, 8'h03);
      bus_read(4'd3, rd);
      check("div_read", rd, 8'h03);
      wait_idle();
      check("two_frame_len", last_len, 80);

      // SEED 0 while idle behaves as 1
      bus_write(4'd3, 8'd0);
      bus_write(4'd2, 8'h00);
      bus_write(4'd0, 8'h00);
      capture_frame(seq);
      check("seq_seed0", seq, 10'h240);
      wait_idle();

      // SEED write while busy is ignored
      bus_write(4'd3, 8'd2);
      bus_write(4'd2, 8'h15);
      bus_write(4'd0, 8'h5A);
      bus_write(4'd2, 8'h3F);
      wait_idle();
      bus_write(4'd3, 8'd0);

      // reset in the middle of data bit 4
      bus_write(4'd0, 8'hFF);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("midrst_sdwr", sdwr, 1'b1);
      check("midrst_sdfrm", sdfrm, 1'b0);
      #1;
      bus_read(4'd1, rd);
      check("midrst_status", rd, 8'h00);
      bus_write(4'd0, 8'h00);
      capture_frame(seq);
      check("seq_after_rst", seq, 10'h240);
      wait_idle();

      // held write produces exactly one frame
      f0 = n_frm_starts;
      sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; ba_lo = 4'd0; br_w = 1'b0; bd_in = 8'h81;
      repeat (5) tick();
      deselect();
      tick();
      wait_idle();
      repeat (3) tick();
      check("held_one_frame", n_frm_starts, f0 + 1);
      bus_read(4'd1, rd);
      check("held_no_ovr", rd, 8'h00);

      // ba13=1 must not select
      f0 = n_frm_starts;
      sser_n = 1'b0; ba13 = 1'b1; ba12 = 1'b1; ba_lo = 4'd0; br_w = 1'b0; bd_in = 8'h42;
      tick();
      br_w = 1'b1; ba_lo = 4'd1;
      @(negedge clk);
      check("ba13_oe", bd_oe, 1'b0);
      #1;
      deselect();
      repeat (20) tick();
      check("ba13_no_frame", n_frm_starts, f0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst    = ($urandom_range(0, 499) == 0);
         sser_n = $urandom_range(0, 1);
         ba13   = ($urandom_range(0, 7) == 0);
         ba12   = ($urandom_range(0, 7) != 0);
         ba_lo  = 4'($urandom_range(0, 4));
         br_w   = $urandom_range(0, 1);
         bd_in  = (ba_lo == 4'd3) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         tick();
      end
      rst = 1'b0;
      deselect();
      repeat (50) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
